// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory-stage load/store engine: load/store flags,
// data-bus request/response structs, transfer sizes and the engine's FSM states.
// Latency: n/a (types and pure helpers only). Backpressure: n/a.
package mem_access_unit_pkg;

  // Decoded memory-access kind coming from the control unit.
  typedef enum logic [2:0] {
    LS_NONE    = 3'd0,
    LS_BTYE    = 3'd1,
    LS_BTYE_U  = 3'd2,
    LS_HALFW   = 3'd3,
    LS_HALFW_U = 3'd4,
    LS_WORD    = 3'd5
  } ls_flag_t;

  // Bus transfer size.
  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_RESP = 2'd3
  } lsu_state_t;

  // Byte accesses can never be misaligned; halfwords need addr[0]=0,
  // words need addr[1:0]=0.
  function automatic logic addr_misaligned(ls_flag_t flag, logic [1:0] offs);
    case (flag)
      LS_HALFW, LS_HALFW_U: return offs[0];
      LS_WORD:              return |offs;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-bus bundle between the load/store engine (master) and memory (slave).
// Ports: dreq = request (valid/addr/size/strobe/data), dresp = addr_ok/data_ok/data.
// Latency: n/a. Backpressure: master holds dreq.valid until dresp.addr_ok.
interface mem_access_unit_if;
  import mem_access_unit_pkg::*;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);

endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Aligns a raw bus word by the byte offset and sign/zero-extends it per ls_flag.
// Ports: ls_flag, offset (addr[1:0]), raw (bus data) in; ext (extended word) out.
// Latency: purely combinational. Backpressure: none.
module load_extend
  import mem_access_unit_pkg::*;
(
  input  ls_flag_t    ls_flag,
  input  logic [1:0]  offset,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  logic [31:0] shifted;

  // Bring the addressed byte/halfword down to bit 0.
  assign shifted = raw >> {offset, 3'b000};

  always_comb begin
    ext = shifted;
    case (ls_flag)
      LS_BTYE:    ext = {{24{shifted[7]}}, shifted[7:0]};
      LS_BTYE_U:  ext = {24'h0, shifted[7:0]};
      LS_HALFW:   ext = {{16{shifted[15]}}, shifted[15:0]};
      LS_HALFW_U: ext = {16'h0, shifted[15:0]};
      default:    ext = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: alignment check, one data-bus request, extended result.
// Ports: clk/resetn; start, ls_flag, mem_write_en, addr, wdata from the pipeline;
//   dbus (master side of the data bus); busy (stall), done pulse, rdata, adel/ades, bad_vaddr.
// Latency: start -> done in 2 cycles best case, +1 per cycle of addr_ok/data_ok delay;
//   misaligned accesses finish in 1 cycle with no bus request.
// Backpressure: dreq.valid and all request fields are held until addr_ok; busy stalls the pipe.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  ls_flag_t          ls_flag,
  input  logic              mem_write_en,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  mem_access_unit_if.master dbus,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              adel,
  output logic              ades,
  output logic [31:0]       bad_vaddr
);

  lsu_state_t  state;
  ls_flag_t    ls_q;
  logic        we_q;
  logic [1:0]  offs_q;

  logic        accept;
  logic        misaligned;
  dbus_req_t   req_enc;
  logic [31:0] load_val;

  assign accept     = start && (ls_flag != LS_NONE);
  assign misaligned = addr_misaligned(ls_flag, addr[1:0]);

  // Stall starts in the same cycle the instruction shows up, before the FSM moves.
  assign busy = (state == LSU_REQ) || (state == LSU_WAIT) ||
                ((state == LSU_IDLE) && accept);

  // Request encoding straight from the pipeline inputs; registered into dreq
  // on acceptance so it stays frozen for the whole handshake.
  always_comb begin
    req_enc       = '0;
    req_enc.valid = 1'b1;
    req_enc.addr  = addr;
    case (ls_flag)
      LS_BTYE, LS_BTYE_U: begin
        req_enc.size   = MSIZE1;
        req_enc.strobe = 4'b0001 << addr[1:0];
        req_enc.data   = {4{wdata[7:0]}};
      end
      LS_HALFW, LS_HALFW_U: begin
        req_enc.size   = MSIZE2;
        req_enc.strobe = 4'b0011 << addr[1:0];
        req_enc.data   = {2{wdata[15:0]}};
      end
      LS_WORD: begin
        req_enc.size   = MSIZE4;
        req_enc.strobe = 4'b1111;
        req_enc.data   = wdata;
      end
      default: req_enc.size = MSIZE1;
    endcase
    if (!mem_write_en) begin
      req_enc.strobe = 4'b0000;
    end
  end

  load_extend u_load_extend (
    .ls_flag (ls_q),
    .offset  (offs_q),
    .raw     (dbus.dresp.data),
    .ext     (load_val)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= LSU_IDLE;
      dbus.dreq <= '0;
      done      <= 1'b0;
      adel      <= 1'b0;
      ades      <= 1'b0;
      rdata     <= '0;
      bad_vaddr <= '0;
      ls_q      <= LS_NONE;
      we_q      <= 1'b0;
      offs_q    <= 2'b00;
    end else begin
      done <= 1'b0;
      case (state)
        LSU_IDLE: begin
          // Responses arriving here belong to a request aborted by reset.
          if (accept) begin
            ls_q   <= ls_flag;
            we_q   <= mem_write_en;
            offs_q <= addr[1:0];
            if (misaligned) begin
              state     <= LSU_RESP;
              done      <= 1'b1;
              adel      <= !mem_write_en;
              ades      <= mem_write_en;
              bad_vaddr <= addr;
              rdata     <= '0;
            end else begin
              state     <= LSU_REQ;
              dbus.dreq <= req_enc;
            end
          end
        end

        LSU_REQ: begin
          // data_ok without addr_ok is a protocol violation and is ignored.
          if (dbus.dresp.addr_ok) begin
            dbus.dreq <= '0;
            if (dbus.dresp.data_ok) begin
              state <= LSU_RESP;
              done  <= 1'b1;
              adel  <= 1'b0;
              ades  <= 1'b0;
              rdata <= we_q ? 32'h0 : load_val;
            end else begin
              state <= LSU_WAIT;
            end
          end
        end

        LSU_WAIT: begin
          if (dbus.dresp.data_ok) begin
            state <= LSU_RESP;
            done  <= 1'b1;
            adel  <= 1'b0;
            ades  <= 1'b0;
            rdata <= we_q ? 32'h0 : load_val;
          end
        end

        LSU_RESP: state <= LSU_IDLE;

        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed + randomized bench for mem_access_unit with a behavioural bus slave
// and an arithmetic reference model of alignment, encoding and load extension.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  ls_flag_t    ls_flag;
  logic        mem_write_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        adel;
  logic        ades;
  logic [31:0] bad_vaddr;

  mem_access_unit_if dbus ();

  mem_access_unit dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .ls_flag      (ls_flag),
    .mem_write_en (mem_write_en),
    .addr         (addr),
    .wdata        (wdata),
    .dbus         (dbus),
    .busy         (busy),
    .done         (done),
    .rdata        (rdata),
    .adel         (adel),
    .ades         (ades),
    .bad_vaddr    (bad_vaddr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Values observed on the last transaction, for constant spot checks.
  logic [31:0] last_rdata;
  logic [3:0]  last_strobe;
  logic [31:0] last_data;
  msize_t      last_size;

  assert property (@(posedge clk) disable iff (!resetn)
                   !(dbus.dreq.valid && dbus.dresp.data_ok && !dbus.dresp.addr_ok))
    else $error("FAIL bus_protocol: data_ok without addr_ok while request pending");

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: expected extended load value from the raw bus word.
  function automatic logic [31:0] model_load(ls_flag_t ls, logic [31:0] raw, logic [1:0] o);
    logic [31:0] s;
    int t;
    s = raw >> (8 * o);
    case (ls)
      LS_BTYE:    begin t = int'(s % 256);   if (t >= 128)   t -= 256;   return 32'(t); end
      LS_BTYE_U:  return s % 256;
      LS_HALFW:   begin t = int'(s % 65536); if (t >= 32768) t -= 65536; return 32'(t); end
      LS_HALFW_U: return s % 65536;
      default:    return s;
    endcase
  endfunction

  // One complete transaction: start at cycle 0, slave gives addr_ok after d_a
  // extra valid cycles and data_ok d_d cycles after addr_ok.
  task automatic run_txn(input string name, input ls_flag_t ls, input logic we,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input int d_a, input int d_d, input logic poke);
    int n, vcnt, ca, done_cyc, vcycles, field_errs, busy_errs, extra_done, exp_done;
    logic mis, a_done, seen;
    logic [3:0]  exp_strobe;
    logic [31:0] exp_data;
    msize_t      exp_size;
    dbus_req_t   snap;
    logic [31:0] o_rdata, o_bad;
    logic        o_adel, o_ades;

    n = (ls == LS_WORD) ? 4 : ((ls == LS_HALFW || ls == LS_HALFW_U) ? 2 : 1);
    mis        = (a % n) != 0;
    exp_size   = (n == 1) ? MSIZE1 : ((n == 2) ? MSIZE2 : MSIZE4);
    exp_strobe = we ? 4'(((1 << n) - 1) << a[1:0]) : 4'b0000;
    exp_data   = (n == 1) ? wd[7:0] * 32'h0101_0101 :
                 ((n == 2) ? wd[15:0] * 32'h0001_0001 : wd);
    exp_done   = mis ? 1 : 2 + d_a + d_d;

    done_cyc = -1; vcycles = 0; field_errs = 0; busy_errs = 0; extra_done = 0;
    vcnt = 0; ca = 0; a_done = 1'b0; seen = 1'b0; snap = '0;
    o_rdata = '0; o_bad = '0; o_adel = 1'b0; o_ades = 1'b0;

    for (int cy = 0; cy < 40; cy++) begin
      @(negedge clk);
      if (cy == 0) begin
        start = 1'b1; ls_flag = ls; mem_write_en = we; addr = a; wdata = wd;
      end else if (poke && cy == 1) begin
        start = 1'b1; ls_flag = LS_WORD; mem_write_en = ~we; addr = a ^ 32'h100; wdata = ~wd;
      end else begin
        start = 1'b0;
      end
      dbus.dresp = '0;
      if (dbus.dreq.valid && !a_done) begin
        vcnt++;
        if (vcnt == d_a + 1) begin
          dbus.dresp.addr_ok = 1'b1; a_done = 1'b1; ca = cy;
        end
      end
      if (a_done && cy == ca + d_d) begin
        dbus.dresp.data_ok = 1'b1; dbus.dresp.data = rd;
      end
      #1;
      if (dbus.dreq.valid) begin
        vcycles++;
        if (!seen) begin snap = dbus.dreq; seen = 1'b1; end
        else if (dbus.dreq !== snap) field_errs++;
      end
      if (busy !== (cy < exp_done)) busy_errs++;
      if (done === 1'b1) begin
        if (done_cyc < 0) begin
          done_cyc = cy; o_rdata = rdata; o_adel = adel; o_ades = ades; o_bad = bad_vaddr;
        end else begin
          extra_done++;
        end
      end
      if (done_cyc >= 0 && cy == done_cyc + 1) break;
    end
    start = 1'b0;
    dbus.dresp = '0;

    last_rdata = o_rdata; last_strobe = snap.strobe; last_data = snap.data; last_size = snap.size;

    check({name, "/done_cycle"}, 72'(done_cyc), 72'(exp_done));
    check({name, "/done_one_cycle"}, 72'(extra_done), 72'(0));
    check({name, "/adel"}, 72'(o_adel), 72'(mis && !we));
    check({name, "/ades"}, 72'(o_ades), 72'(mis && we));
    check({name, "/valid_cycles"}, 72'(vcycles), 72'(mis ? 0 : d_a + 1));
    check({name, "/field_stable"}, 72'(field_errs), 72'(0));
    check({name, "/busy"}, 72'(busy_errs), 72'(0));
    if (mis) begin
      check({name, "/bad_vaddr"}, 72'(o_bad), 72'(a));
    end else begin
      check({name, "/rdata"}, 72'(o_rdata), 72'(we ? 32'h0 : model_load(ls, rd, a[1:0])));
      check({name, "/req_addr"}, 72'(snap.addr), 72'(a));
      check({name, "/req_size"}, 72'(snap.size), 72'(exp_size));
      check({name, "/req_strobe"}, 72'(snap.strobe), 72'(exp_strobe));
      if (we) check({name, "/req_data"}, 72'(snap.data), 72'(exp_data));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int idle_done, idle_valid;
    ls_flag_t rl;
    logic     rw;
    logic [31:0] ra;

    resetn = 1'b0; start = 1'b0; ls_flag = LS_NONE; mem_write_en = 1'b0;
    addr = '0; wdata = '0; dbus.dresp = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset/dreq", 72'(dbus.dreq), 72'(0));
    check("reset/busy", 72'(busy), 72'(0));
    check("reset/done", 72'(done), 72'(0));
    check("reset/rdata", 72'(rdata), 72'(0));
    check("reset/adel_ades", 72'({adel, ades}), 72'(0));
    check("reset/bad_vaddr", 72'(bad_vaddr), 72'(0));
    @(negedge clk);
    resetn = 1'b1;

    run_txn("lb", LS_BTYE, 1'b0, 32'h8000_0003, 32'h0, 32'h8012_3456, 0, 0, 1'b0);
    check("lb/rdata_const", 72'(last_rdata), 72'(32'hFFFF_FF80));
    check("lb/strobe_const", 72'(last_strobe), 72'(0));
    run_txn("lbu", LS_BTYE_U, 1'b0, 32'h8000_0003, 32'h0, 32'h8012_3456, 0, 0, 1'b0);
    check("lbu/rdata_const", 72'(last_rdata), 72'(32'h0000_0080));

    run_txn("sh", LS_HALFW, 1'b1, 32'h8000_0002, 32'h1234_ABCD, 32'h0, 3, 0, 1'b0);
    check("sh/strobe_const", 72'(last_strobe), 72'(4'b1100));
    check("sh/data_const", 72'(last_data), 72'(32'hABCD_ABCD));
    check("sh/size_const", 72'(last_size), 72'(MSIZE2));

    run_txn("lw_mis", LS_WORD, 1'b0, 32'h8000_0006, 32'h0, 32'h0, 0, 0, 1'b0);
    run_txn("sw_mis", LS_WORD, 1'b1, 32'h8000_0001, 32'h1111_2222, 32'h0, 0, 0, 1'b0);

    run_txn("lhu_wait", LS_HALFW_U, 1'b0, 32'h8000_0000, 32'h0, 32'h0000_F00D, 0, 3, 1'b0);
    check("lhu_wait/rdata_const", 72'(last_rdata), 72'(32'h0000_F00D));

    // Abort a load in WAIT by reset, then feed it a stale response.
    @(negedge clk);
    start = 1'b1; ls_flag = LS_HALFW_U; mem_write_en = 1'b0; addr = 32'h8000_0010;
    @(negedge clk);
    start = 1'b0; dbus.dresp.addr_ok = dbus.dreq.valid;
    @(negedge clk);
    dbus.dresp = '0;
    #1;
    check("abort/wait_valid", 72'(dbus.dreq.valid), 72'(0));
    check("abort/wait_busy", 72'(busy), 72'(1));
    resetn = 1'b0;
    #1;
    check("abort/dreq", 72'(dbus.dreq), 72'(0));
    check("abort/busy", 72'(busy), 72'(0));
    check("abort/flags", 72'({done, adel, ades}), 72'(0));
    check("abort/rdata", 72'(rdata), 72'(0));
    check("abort/bad_vaddr", 72'(bad_vaddr), 72'(0));
    @(negedge clk);
    resetn = 1'b1;
    idle_done = 0; idle_valid = 0;
    for (int cy = 0; cy < 5; cy++) begin
      @(negedge clk);
      dbus.dresp = '0;
      if (cy == 0) begin dbus.dresp.data_ok = 1'b1; dbus.dresp.data = 32'hDEAD_BEEF; end
      #1;
      if (done === 1'b1) idle_done++;
      if (dbus.dreq.valid === 1'b1) idle_valid++;
    end
    dbus.dresp = '0;
    check("stale/done", 72'(idle_done), 72'(0));
    check("stale/valid", 72'(idle_valid), 72'(0));
    check("stale/rdata", 72'(rdata), 72'(0));

    run_txn("sb", LS_BTYE, 1'b1, 32'h8000_0001, 32'h0000_0055, 32'h0, 0, 0, 1'b0);
    check("sb/strobe_const", 72'(last_strobe), 72'(4'b0010));
    check("sb/data_const", 72'(last_data), 72'(32'h5555_5555));

    // start with LS_NONE: no stall, no request, no completion.
    @(negedge clk);
    start = 1'b1; ls_flag = LS_NONE; mem_write_en = 1'b0; addr = 32'h8000_0020;
    #1;
    check("none/busy", 72'(busy), 72'(0));
    idle_done = 0; idle_valid = 0;
    for (int cy = 0; cy < 4; cy++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (done === 1'b1) idle_done++;
      if (dbus.dreq.valid === 1'b1) idle_valid++;
    end
    check("none/done", 72'(idle_done), 72'(0));
    check("none/valid", 72'(idle_valid), 72'(0));

    run_txn("poke_lw", LS_WORD, 1'b0, 32'h8000_0040, 32'h0, 32'hCAFE_F00D, 2, 1, 1'b1);

    for (int i = 0; i < 40; i++) begin
      rl = ls_flag_t'(3'($urandom_range(1, 5)));
      rw = 1'($urandom_range(0, 1));
      ra = $urandom;
      run_txn($sformatf("rand%0d", i), rl, rw, ra, $urandom, $urandom,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
